// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, long-command codes and wait defaults for the LCD bus arbiter
package lcd_pkg;
    typedef enum logic [2:0] {IDLE, HI_EN, HI_DIS, LO_EN, LO_DIS, WAIT} state_t;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;
    localparam int WAIT_SHORT_DEF = 1;
    localparam int WAIT_LONG_DEF  = 2;
    function automatic logic is_long(input logic rs, input logic [7:0] b);
        return !rs && (b == CMD_CLEAR || b == CMD_HOME || b == CMD_HOME_ALT);
    endfunction
endpackage

// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: sends one byte as two enable-strobed nibbles, then holds off for the post-byte wait
module lcd_nibble_tx import lcd_pkg::*; #(
    parameter int WAIT_SHORT = WAIT_SHORT_DEF,
    parameter int WAIT_LONG  = WAIT_LONG_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       start_rs,
    input  logic [7:0] start_byte,
    output logic       idle,
    output logic       en,
    output logic       rs,
    output logic [3:0] data,
    output logic       busy
);
    // counter is loaded with cycles-minus-one so WAIT exits when it reads zero
    localparam logic [7:0] SHORT_LOAD = 8'(WAIT_SHORT > 1 ? WAIT_SHORT - 1 : 0);
    localparam logic [7:0] LONG_LOAD  = 8'(WAIT_LONG > 1 ? WAIT_LONG - 1 : 0);
    state_t state, next_state;
    logic [7:0] cnt, cnt_next, byte_q, byte_next;
    logic en_next, rs_next, busy_next;
    logic [3:0] data_next;
    assign idle = state == IDLE;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            byte_q <= '0;
            en     <= 1'b0;
            rs     <= 1'b0;
            data   <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= cnt_next;
            byte_q <= byte_next;
            en     <= en_next;
            rs     <= rs_next;
            data   <= data_next;
            busy   <= busy_next;
        end
    end
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE:    next_state = start ? HI_EN : IDLE;
            HI_EN:   next_state = HI_DIS;
            HI_DIS:  next_state = LO_EN;
            LO_EN:   next_state = LO_DIS;
            LO_DIS: begin
                next_state = WAIT;
                cnt_next   = is_long(rs, byte_q) ? LONG_LOAD : SHORT_LOAD;
            end
            WAIT: begin
                next_state = cnt == '0 ? IDLE : WAIT;
                cnt_next   = cnt == '0 ? cnt : cnt - 8'd1;
            end
            default: next_state = IDLE;
        endcase
    end
    // outputs are computed from the next state so the registers line up with it
    always_comb begin
        byte_next = (idle && start) ? start_byte : byte_q;
        rs_next   = (idle && start) ? start_rs : rs;
        en_next   = next_state == HI_EN || next_state == LO_EN;
        data_next = next_state == HI_EN ? start_byte[7:4] :
                    next_state == LO_EN ? byte_q[3:0] : data;
        busy_next = next_state != IDLE;
    end
endmodule

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: two-requester round-robin arbiter with owner lock in front of a 4-bit LCD writer
module lcd_bus_arbiter import lcd_pkg::*; #(
    parameter int CLOCK_RATE = 1000,
    parameter int WAIT_SHORT = WAIT_SHORT_DEF,
    parameter int WAIT_LONG  = WAIT_LONG_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_valid,
    input  logic       req_rs0,
    input  logic       req_rs1,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    input  logic [1:0] req_lock,
    output logic [1:0] req_ready,
    output logic       en,
    output logic       rs,
    output logic [3:0] data,
    output logic       busy
);
    localparam bit RATE_OK = CLOCK_RATE > 0;
    logic last_served, winner, idle, start;
    // a locked owner keeps the bus even when idle; otherwise alternate on contention
    assign winner = req_lock[last_served] ? last_served :
                    (&req_valid) ? ~last_served : ~req_valid[0];
    assign req_ready[0] = RATE_OK && reset_n && idle && !winner && req_valid[0];
    assign req_ready[1] = RATE_OK && reset_n && idle && winner && req_valid[1];
    assign start = |req_ready;
    always_ff @(posedge clk) begin
        if (!reset_n)
            last_served <= 1'b1;
        else if (start)
            last_served <= winner;
    end
    lcd_nibble_tx #(
        .WAIT_SHORT(WAIT_SHORT),
        .WAIT_LONG (WAIT_LONG)
    ) u_tx (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .start_rs  (winner ? req_rs1 : req_rs0),
        .start_byte(winner ? req_data1 : req_data0),
        .idle      (idle),
        .en        (en),
        .rs        (rs),
        .data      (data),
        .busy      (busy)
    );
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed vectors with hand-computed expectations for lcd_bus_arbiter
module tb_lcd_bus_arbiter;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req_valid = '0;
    logic       req_rs0 = 1'b0;
    logic       req_rs1 = 1'b0;
    logic [7:0] req_data0 = '0;
    logic [7:0] req_data1 = '0;
    logic [1:0] req_lock = '0;
    logic [1:0] req_ready;
    logic       en, rs, busy;
    logic [3:0] data;
    int errors = 0;
    int checks = 0;
    int en_double = 0;
    logic en_prev = 1'b0;

    lcd_bus_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_rs0  (req_rs0),
        .req_rs1  (req_rs1),
        .req_data0(req_data0),
        .req_data1(req_data1),
        .req_lock (req_lock),
        .req_ready(req_ready),
        .en       (en),
        .rs       (rs),
        .data     (data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (en && en_prev) en_double++;
        en_prev = en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic wait_any(output int n);
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic gap_to_ready(input int i, output int n);
        n = 1;
        #1;
        while (req_ready[i] == 1'b0 && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [7:0] bytes [3];
        logic rdy_seen, en_seen;
        bytes = '{8'hC0, 8'h31, 8'h32};

        // reset state, with both requesters valid to prove ready is gated
        req_valid = 2'b11;
        step();
        step();
        check("rst_en", en, 0);
        check("rst_rs", rs, 0);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);

        // single byte 0x41 from req0
        req_valid = 2'b01;
        req_rs0 = 1'b1;
        req_data0 = 8'h41;
        reset_n = 1'b1;
        #1;
        check("single_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        #1;
        check("t1_en", en, 1);
        check("t1_data", data, 4'h4);
        check("t1_rs", rs, 1);
        check("t1_busy", busy, 1);
        check("t1_ready", req_ready, 0);
        step();
        check("t2_en", en, 0);
        check("t2_data", data, 4'h4);
        step();
        check("t3_en", en, 1);
        check("t3_data", data, 4'h1);
        step();
        check("t4_en", en, 0);
        check("t4_data", data, 4'h1);
        step();
        check("t5_busy", busy, 1);
        step();
        check("t6_busy", busy, 0);

        // long command from req1, then the same byte as data
        req_valid = 2'b10;
        req_rs1 = 1'b0;
        req_data1 = 8'h01;
        #1;
        check("long_ready", req_ready, 2'b10);
        step();
        check("long_rs", rs, 0);
        req_rs1 = 1'b1;
        gap_to_ready(1, n);
        check("long_gap", n, 7);
        step();
        check("short_rs", rs, 1);
        gap_to_ready(1, n);
        check("short_gap", n, 6);

        // contention at reset exit alternates starting with req0
        req_valid = 2'b11;
        req_rs0 = 1'b1;
        req_rs1 = 1'b1;
        req_data0 = 8'h5A;
        req_data1 = 8'h6B;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            wait_any(n);
            check($sformatf("arb_%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
            step();
            check($sformatf("arb_hi_%0d", k), data, (k % 2) ? 4'h6 : 4'h5);
        end

        // req0 locks for three bytes while req1 waits
        req_valid = 2'b11;
        req_lock = 2'b01;
        req_rs0 = 1'b0;
        req_data0 = bytes[0];
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wait_any(n);
            check($sformatf("lock_%0d", k), req_ready, 2'b01);
            step();
            check($sformatf("lock_hi_%0d", k), data, {28'd0, bytes[k][7:4]});
            if (k == 2) begin
                req_lock = 2'b00;
                req_valid = 2'b10;
            end else begin
                req_rs0 = 1'b1;
                req_data0 = bytes[k + 1];
            end
        end
        wait_any(n);
        check("lock_release", req_ready, 2'b10);

        // reset during LO_EN abandons the byte
        req_valid = 2'b01;
        req_lock = 2'b00;
        req_rs0 = 1'b1;
        req_data0 = 8'h41;
        do_reset();
        check("mid_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b11;
        step();
        step();
        check("mid_lo_en", en, 1);
        check("mid_lo_data", data, 4'h1);
        reset_n = 1'b0;
        step();
        check("mid_rst_en", en, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rs", rs, 0);
        check("mid_rst_ready", req_ready, 0);
        reset_n = 1'b1;
        #1;
        check("mid_after", req_ready, 2'b01);

        // locked owner goes idle: req1 must not be served
        req_valid = 2'b01;
        req_lock = 2'b01;
        do_reset();
        check("idle_own_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b10;
        for (int k = 0; k < 5; k++) step();
        check("idle_own_done", busy, 0);
        rdy_seen = 1'b0;
        en_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            rdy_seen |= |req_ready;
            en_seen |= en;
        end
        check("idle_own_noready", rdy_seen, 0);
        check("idle_own_noen", en_seen, 0);
        req_lock = 2'b00;
        #1;
        check("idle_own_release", req_ready, 2'b10);

        check("en_never_double", en_double, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 1000, clk frequency in Hz (1 kHz, 1 ms per cycle).
REQ-002 SHALL have parameter WAIT_SHORT, default 1, post-byte wait cycles for ordinary bytes.
REQ-003 SHALL have parameter WAIT_LONG, default 2, post-byte wait cycles for clear/home commands.
REQ-004 SHALL have port clk, input, 1 bit; the single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit; reset is synchronous and active-low.
REQ-006 SHALL have ports req_valid, input, 2 bits; per-requester byte pending.
REQ-007 SHALL have ports req_rs0 and req_rs1, input, 1 bit each; byte is data (1) or command (0).
REQ-008 SHALL have ports req_data0 and req_data1, input, 8 bits each; byte to write.
REQ-009 SHALL have ports req_lock, input, 2 bits; requester holds bus ownership across bytes.
REQ-010 SHALL have ports req_ready, output, 2 bits; byte accepted this cycle.
REQ-011 SHALL have port en, output, 1 bit; LCD enable strobe.
REQ-012 SHALL have port rs, output, 1 bit; LCD register select.
REQ-013 SHALL have port data, output, 4 bits; LCD nibble bus.
REQ-014 SHALL have port busy, output, 1 bit; high whenever the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, HI_EN, HI_DIS, LO_EN, LO_DIS, WAIT.
REQ-016 In IDLE, the winner SHALL be chosen as follows: if owner lock is active, only the owner is eligible; otherwise the requester not served last wins when both are valid, and the sole valid requester wins when only one is.
REQ-017 Owner lock SHALL be active while req_lock[last_served] is high; lock SHALL be sampled only in IDLE.
REQ-018 req_ready[i] SHALL be combinational: IDLE && winner==i && req_valid[i]; at most one bit high.
REQ-019 On accept, the block SHALL capture rs/byte, set last_served=i and go to HI_EN.
REQ-020 HI_EN SHALL drive en=1, data=byte[7:4], rs=captured; HI_DIS SHALL drive en=0 with data/rs held.
REQ-021 LO_EN SHALL drive en=1, data=byte[3:0]; LO_DIS SHALL drive en=0 with data/rs held.
REQ-022 Each of HI_EN, HI_DIS, LO_EN and LO_DIS SHALL last exactly one cycle.
REQ-023 WAIT SHALL last WAIT_LONG cycles if rs=0 and byte is 0x01, 0x02 or 0x03, else WAIT_SHORT cycles; the counter SHALL be width-safe up to 255.
REQ-024 WAIT SHALL return to IDLE.
REQ-025 Accept-to-accept minimum SHALL be 5+WAIT cycles: accept at T, en high at T+1 and T+3, next accept at T+5+WAIT.
REQ-026 A requester SHALL hold valid/rs/data stable until ready; dropping valid before ready withdraws the byte with no bus activity.
REQ-027 If the lock owner is not valid while locked, no byte SHALL be accepted; the other requester waits (no timeout).
REQ-028 If the lock is released in the same cycle as the owner's final accept, that accept SHALL still apply; arbitration reverts at the next IDLE.
REQ-029 Outputs SHALL be registered; en SHALL never be high in two consecutive cycles.

Reset
REQ-030 While reset_n is low at a clock edge, the block SHALL set state=IDLE, en=0, rs=0, data=0, busy=0, last_served=1 (requester 0 first) and clear the wait counter.
REQ-031 Reset mid-byte SHALL abandon the byte: en=0 at the next edge, no ready asserted during reset, and the byte is not resumed.

Structure
REQ-032 Shared package lcd_pkg SHALL hold the state enumeration, the long-command codes 0x01/0x02/0x03 and the default wait constants.
REQ-033 The nibble sequencer (HI_EN..WAIT plus wait counter) SHALL be sub-module lcd_nibble_tx; arbitration SHALL stay in the top.

Verification
REQ-034 Single request: req0 rs=1 data=0x41 -> en pulses at T+1 and T+3, data=0x4 then 0x1, rs=1, busy low at T+6.
REQ-035 Contention: both valid at reset exit -> req0 served first, then req1; the alternation holds for 4 bytes each.
REQ-036 Long wait: req1 rs=0 data=0x01 -> WAIT lasts 2 cycles, next ready at T+7; the same byte with rs=1 -> next ready at T+6.
REQ-037 Lock: req0 locks and sends 0xC0,0x31,0x32 while req1 is valid -> req1 stays unserved until req0 lock drops, then is served next.
REQ-038 Reset mid-operation: reset_n low during LO_EN -> en=0, data=0, busy=0 next cycle; after release, req0 wins.
REQ-039 Lock owner idle: req0 lock=1, valid=0 with req1 valid for 10 cycles -> req_ready stays 0 and en stays 0.
